// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide beside EX: 34-cycle latency, 1 cycle for divide special cases
// (and for all multiplies when MULDIV_FAST_MUL_EN is defined). Holds stall_req while busy; flush aborts silently.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  typedef struct packed {
    logic div;  // divide, else multiply
    logic sel;  // remainder (divide) or high product word (multiply)
    logic neg;  // negate the magnitude result in FIX
  } op_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_next;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc, acc_next, prod_fix;
  logic [XLEN-1:0]   opb, mag1, mag2, special_res, fix_val, div_val;
  logic [XLEN:0]     rem_sh, add_sum;
  op_t               op, op_in;
  logic              accept, special, sgn1, sgn2, neg1, neg2;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{sgn1 & src1[XLEN-1]}}, src1} * {{XLEN{sgn2 & src2[XLEN-1]}}, src2};
`endif

  always_comb begin
    sgn1      = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    sgn2      = funct3[2] ? ~funct3[0] : ~funct3[1];
    neg1      = sgn1 & src1[XLEN-1];
    neg2      = sgn2 & src2[XLEN-1];
    mag1      = neg1 ? -src1 : src1;
    mag2      = neg2 ? -src2 : src2;
    op_in.div = funct3[2];
    op_in.sel = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
    // Remainder follows the dividend's sign; everything else negates when signs differ.
    op_in.neg = (funct3[2] & funct3[1]) ? neg1 : (neg1 ^ neg2);
  end

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (funct3[2] && src2 == '0) begin
      special     = 1'b1;
      special_res = funct3[1] ? src1 : '1;
    end else if (funct3[2] && !funct3[0] && src1 == MIN_INT && src2 == '1) begin
      special     = 1'b1;
      special_res = funct3[1] ? '0 : MIN_INT;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!funct3[2]) begin
      special     = 1'b1;
      special_res = op_in.sel ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0];
    end
`endif
  end

  // acc holds {remainder, dividend/quotient} for divide, {product high, multiplier/product low} for multiply.
  always_comb begin
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    if (op.div) begin
      if (rem_sh >= {1'b0, opb})
        acc_next = {rem_sh[XLEN-1:0] - opb, acc[XLEN-2:0], 1'b1};
      else
        acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[XLEN-1:1]};
    end
    prod_fix = op.neg ? -acc : acc;
    div_val  = op.sel ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (op.div)
      fix_val = op.neg ? -div_val : div_val;
    else
      fix_val = op.sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          accept     = 1'b1;
          state_next = special ? DONE : CALC;
        end
      end
      CALC:    if (cnt == 6'd31) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
    busy      = (state == CALC) || (state == FIX);
    done      = (state == DONE);
    stall_req = accept || busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      op     <= '0;
      result <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op  <= op_in;
        cnt <= '0;
        opb <= funct3[2] ? mag2 : mag1;
        acc <= {{XLEN{1'b0}}, (funct3[2] ? mag1 : mag2)};
        if (special) result <= special_res;
      end
      if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt + 6'd1;
      end
      if (state == FIX && !flush) result <= fix_val;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: driver queues expected result/latency from an arithmetic
// reference model; a negedge monitor checks stall_req/busy/done/result every cycle.
module tb_muldiv_unit;

  logic        clk, rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] src1, src2, result;
  logic        stall_req, busy, done;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .src1(src1), .src2(src2),
    .flush(flush), .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    int          ab_age;
    bit          ab_rst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        me;
  int          age;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_res = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    ia = signed'(a);
    ib = signed'(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return $urandom_range(0, 15);
      default: return $urandom();
    endcase
  endfunction

  // Called at posedge+1; leaves start high on normal completion so the caller may go back-to-back.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int ab_age, input bit ab_rst);
    exp_t e;
    int   n;
    funct3 = f3; src1 = a; src2 = b; start = 1'b1;
    e.res = ref_res(f3, a, b);
    e.lat = ref_lat(f3, a, b);
    e.t0 = cyc;
    e.ab_age = ab_age;
    e.ab_rst = ab_rst;
    exp_q.push_back(e);
    if (ab_age >= 0) begin
      repeat (ab_age) @(posedge clk);
      #1;
      if (ab_rst) rst = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; flush = 1'b0; start = 1'b0;
    end else begin
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 100) chk("op_timeout", 32'(n), 32'd34);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() != 0) begin
        me  = exp_q[0];
        age = cyc - me.t0;
        chk("stall_req", 32'(stall_req), 32'(age < me.lat));
        chk("busy", 32'(busy), 32'(age >= 1 && age < me.lat));
        chk("done", 32'(done), 32'(age == me.lat));
        chk("result", result, (age == me.lat) ? me.res : last_res);
        if (age == me.ab_age) begin
          void'(exp_q.pop_front());
          if (me.ab_rst) last_res = 32'h0;
        end else if (age >= me.lat) begin
          void'(exp_q.pop_front());
          last_res = me.res;
        end
      end else begin
        chk("idle_stall_req", 32'(stall_req), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_result", result, last_res);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; src1 = 32'h0; src2 = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, -1, 1'b0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    do_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 1'b0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, -1, 1'b0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, -1, 1'b0);
    do_op(3'd5, 32'd100, 32'd7, -1, 1'b0);
    do_op(3'd7, 32'd100, 32'd7, -1, 1'b0);
    start = 1'b0;
    @(posedge clk);
    #1;
    // start together with flush in IDLE must not be accepted
    funct3 = 3'd4; src1 = 32'd9; src2 = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'd5, 32'd1000, 32'd3, 10, 1'b0);
    @(posedge clk);
    #1;
    do_op(3'd5, 32'd1000, 32'd3, -1, 1'b0);
    do_op(3'd4, 32'd5, 32'd0, -1, 1'b0);
    do_op(3'd6, 32'd5, 32'd0, -1, 1'b0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, -1, 1'b0);
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, -1, 1'b0);
    do_op(3'd7, 32'hDEADBEEF, 32'd12345, 15, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), -1, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        start = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit beside the EX-stage ALU. It accepts one M-extension operation from EX and computes it over multiple cycles. While working it holds a stall request that the hazard logic uses to freeze PC and IF/ID and to bubble ID/EX. It returns a registered 32-bit result with a one-cycle `done` pulse that the EX/MEM register captures.

## Interface
- `XLEN`, default 32, operand/result width; only 32 is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: EX holds an M-extension op (opcode 0110011, funct7 0000001); level, held until the pipeline advances.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src1` input 32: rs1 value, already forwarded.
- `src2` input 32: rs2 value, already forwarded.
- `flush` input 1: EX instruction is being killed (branch/jump redirect); aborts the operation.
- `stall_req` output 1: request to freeze PC and IF/ID and clear ID/EX.
- `busy` output 1: state is neither IDLE nor DONE.
- `done` output 1: one-cycle pulse; `result` is valid.
- `result` output 32: registered result, held until the next accepted start.

## Operation
- States and transitions:
  - IDLE: accept when `start & ~flush`.
  - Accept goes to CALC, or straight to DONE for special cases.
  - CALC runs 32 iterations, counted by a 6-bit counter.
  - CALC goes to FIX, which applies sign correction and selects high/low word.
  - FIX goes to DONE, which lasts one cycle and then returns to IDLE.
- Accept latches: operand magnitudes, operation, result-sign flags, counter = 0.
- Multiply:
  - Radix-2 shift-add on 32-bit magnitudes into a 64-bit product.
  - Signed-ness per operand: MULH s×s, MULHSU s×u, MULHU u×u, MUL either (low word).
  - FIX negates the 64-bit product if the signs differ.
  - MUL returns [31:0]; the others return [63:32].
- Divide:
  - Restoring division on magnitudes, 33-bit partial remainder.
  - Quotient is negative iff the signs differ (DIV); remainder takes the dividend's sign (REM).
- Special cases, decided at accept, skip CALC/FIX:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src1.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; REM of the same gives 0.
- `start` in CALC, FIX or DONE is ignored. The pipeline is frozen, so it is the same instruction.
- `flush` in any state returns to IDLE on the next edge. No `done` is produced and `result` is unchanged.
- `flush` and `start` together in IDLE: not accepted.
- Reset mid-operation: state IDLE, counter 0, all outputs at reset values on the next edge.

## Timing
- Reset values: `stall_req`=0, `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
- `stall_req` is combinational: `(state==IDLE & start & ~flush) | busy`. It asserts in the same cycle EX presents the op.
- `stall_req` is low in DONE, so the pipeline advances on the DONE edge and EX/MEM captures `result`.
- Normal latency: accept edge k, CALC on edges k+1..k+32, FIX on edge k+33, `done` high during cycle k+34 → 34 cycles.
- Special-case latency: `done` high in the cycle after the accept edge.
- Back-to-back: a new `start` is accepted at the earliest in the cycle after DONE, i.e. in IDLE.
- `result` changes only on the FIX→DONE edge or the special-case accept edge.

## Configuration
- `MULDIV_FAST_MUL_EN`
  - Defined: all multiplies use a single-cycle 33×33 signed `*` computed at accept. They behave like special cases: DONE next cycle, `done` latency 1. CALC/FIX are used for divide only.
  - Undefined: multiplies use iterative shift-add with 34-cycle latency.
- Divide behaviour is identical in both builds.

## Test plan
- MUL src1=7, src2=0xFFFFFFFD → `result`=0xFFFFFFEB, `done` exactly 34 cycles after accept; `stall_req` high from the start cycle through FIX.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, `done` one cycle after accept. DIV 0x80000000/−1 → 0x80000000, REM → 0.
- DIVU accepted, `flush` asserted on cycle 10 of CALC → `busy`/`stall_req` low next cycle, no `done`, `result` keeps its previous value. A new op started afterwards completes correctly.
- `rst` asserted mid-CALC → all outputs 0 next cycle. Build with `MULDIV_FAST_MUL_EN` → MUL 7×−3 completes with `done` latency 1.
